// File: rtl/rv_main_fsm_if.sv
// Control-state bundle between the instruction register, the next-state
// sequencer and the control-signal decoder of the RV32I multicycle core.
interface rv_main_fsm_if #(
  parameter int unsigned INSTRET_W = 32
) ();
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [4:0]           state;
  logic                 retire;
  logic                 halted;
  logic                 illegal;
  logic [INSTRET_W-1:0] instret;

  modport master (
    output opcode, funct3,
    input  state, retire, halted, illegal, instret
  );

  modport slave (
    input  opcode, funct3,
    output state, retire, halted, illegal, instret
  );
endinterface

// File: rtl/rv_main_fsm.sv
// Next-state sequencer for the RV32I multicycle core: advances the control
// state from the IR opcode/funct3, halts on SYSTEM/illegal, counts retirements.
module rv_main_fsm #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  rv_main_fsm_if.slave bus
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEM_ADDR = 5'd2,
    S_MEM_READ = 5'd3,
    S_LOAD_WB  = 5'd4,
    S_STORE    = 5'd5,
    S_R_EXEC   = 5'd6,
    S_R_WB     = 5'd7,
    S_BEQ      = 5'd8,
    S_I_EXEC   = 5'd9,
    S_I_WB     = 5'd10,
    S_JAL      = 5'd11,
    S_JALR     = 5'd12,
    S_BNE      = 5'd13,
    S_BLT      = 5'd14,
    S_BGE      = 5'd15,
    S_BLTU     = 5'd16,
    S_BGEU     = 5'd17,
    S_AUIPC    = 5'd18,
    S_LUI      = 5'd19
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t               state_q, state_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;
  logic                 retire;
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      if (retire) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  // Halting leaves state_d at S_DECODE, so a halted core simply re-enters decode
  // forever; decode is gated by halted_q so nothing else can move it.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        if (!halted_q) begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
            OP_OP:             state_d = S_R_EXEC;
            OP_IMM:            state_d = S_I_EXEC;
            OP_JAL:            state_d = S_JAL;
            OP_AUIPC:          state_d = S_AUIPC;
            OP_LUI:            state_d = S_LUI;
            OP_JALR: begin
              if (bus.funct3 == 3'b000) begin
                state_d = S_JALR;
              end else begin
                halted_d  = 1'b1;
                illegal_d = 1'b1;
              end
            end
            OP_BRANCH: begin
              case (bus.funct3)
                3'b000:  state_d = S_BEQ;
                3'b001:  state_d = S_BNE;
                3'b100:  state_d = S_BLT;
                3'b101:  state_d = S_BGE;
                3'b110:  state_d = S_BLTU;
                3'b111:  state_d = S_BGEU;
                default: begin
                  halted_d  = 1'b1;
                  illegal_d = 1'b1;
                end
              endcase
            end
            OP_FENCE: begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
            OP_SYSTEM: begin
              halted_d  = 1'b1;
              illegal_d = 1'b0;
            end
            default: begin
              halted_d  = 1'b1;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_LOAD) ? S_MEM_READ : S_STORE;
      S_MEM_READ: state_d = S_LOAD_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_LOAD_WB, S_STORE, S_R_WB, S_BEQ, S_I_WB, S_JAL, S_JALR,
      S_BNE, S_BLT, S_BGE, S_BLTU, S_BGEU, S_AUIPC, S_LUI: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:    state_d = S_FETCH;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.retire  = retire;
  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;
  assign bus.instret = instret_q;

endmodule
